// File: rtl/game_2048_core.sv
`timescale 1ns/1ps
// Sequential 2048 engine: cells hold tile exponents, one line is shifted/merged per cycle,
// new tiles are placed by an LFSR-driven cell scan, then win/loss is evaluated.
module game_2048_core #(
  parameter int          N       = 4,
  parameter int          EXP_W   = 4,
  parameter int          WIN_EXP = 11,
  parameter int          SCORE_W = 20,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   move_valid,
  input  logic [1:0]             move_dir,
  output logic                   move_ready,
  input  logic                   load_valid,
  input  logic [N*N*EXP_W-1:0]   load_board,
  output logic [N*N*EXP_W-1:0]   board,
  output logic [SCORE_W-1:0]     score,
  output logic [2:0]             state,
  output logic                   done,
  output logic                   moved,
  output logic                   won,
  output logic                   lost
);

  localparam int BW   = N * N * EXP_W;
  localparam int IDXW = $clog2(N * N);
  localparam int LW   = $clog2(N);
  localparam int SW   = ((SCORE_W > (1 << EXP_W)) ? SCORE_W : (1 << EXP_W)) + 4;
  localparam logic [EXP_W-1:0]   E_MAX     = '1;
  localparam logic [EXP_W:0]     WIN_E     = (EXP_W + 1)'(WIN_EXP);
  localparam logic [SW-1:0]      ONE_SW    = {{(SW - 1){1'b0}}, 1'b1};
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_SPAWN = 3'd2,
    S_CHECK = 3'd3,
    S_WON   = 3'd4,
    S_LOST  = 3'd5
  } state_t;

  state_t               state_r, state_nx_s;
  logic [BW-1:0]        board_r;
  logic [SCORE_W-1:0]   score_r, score_nx_s;
  logic [15:0]          lfsr_r;
  logic [1:0]           dir_r;
  logic [LW-1:0]        line_r;
  logic                 changed_r, boot_r, op_r;
  logic [IDXW-1:0]      spawn_idx_r, spawn_cnt_r;
  logic                 done_r, moved_r, won_r, lost_r, move_ready_r;

  logic [IDXW-1:0]      lidx_s [N];
  logic [EXP_W-1:0]     lin_s  [N];
  logic [EXP_W-1:0]     cmp_s  [N+1];
  logic [EXP_W-1:0]     res_s  [N];
  logic [SW-1:0]        gain_s, sum_s;
  logic                 line_chg_s;
  logic                 spawn_hit_s, spawn_end_s, start_spawn_s;
  logic [EXP_W-1:0]     spawn_val_s;
  logic                 any_win_s, any_empty_s, any_pair_s;
  logic                 lfsr_fb_s;

  function automatic logic [EXP_W-1:0] cell_at(input logic [BW-1:0] b, input int idx);
    return b[idx*EXP_W +: EXP_W];
  endfunction

  assign lfsr_fb_s = lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10];

  // Gather the current line ordered from the wall outward, slide, then merge pairs.
  always_comb begin
    int rr, cc, wp;
    logic skip;
    rr = 0; cc = 0; wp = 0; skip = 1'b0;
    gain_s = '0; line_chg_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      case (dir_r)
        2'd0:    begin rr = int'(line_r); cc = N - 1 - k;    end
        2'd1:    begin rr = k;            cc = int'(line_r); end
        2'd2:    begin rr = N - 1 - k;    cc = int'(line_r); end
        default: begin rr = int'(line_r); cc = k;            end
      endcase
      lidx_s[k] = IDXW'(rr * N + cc);
      lin_s[k]  = cell_at(board_r, rr * N + cc);
    end
    for (int k = 0; k <= N; k++) cmp_s[k] = '0;
    for (int k = 0; k < N; k++) res_s[k] = '0;
    for (int k = 0; k < N; k++) begin
      if (lin_s[k] != '0) begin
        cmp_s[wp] = lin_s[k];
        wp++;
      end else begin
        wp = wp;
      end
    end
    wp = 0;
    // cmp_s[N] is always empty, so the k+1 lookahead never pairs past the line end.
    for (int k = 0; k < N; k++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (cmp_s[k] != '0) begin
        if (cmp_s[k] == cmp_s[k+1] && cmp_s[k] != E_MAX) begin
          res_s[wp] = cmp_s[k] + EXP_W'(1);
          gain_s    = gain_s + (ONE_SW << (cmp_s[k] + EXP_W'(1)));
          skip      = 1'b1;
        end else begin
          res_s[wp] = cmp_s[k];
        end
        wp++;
      end else begin
        skip = 1'b0;
      end
    end
    for (int k = 0; k < N; k++) begin
      if (res_s[k] != lin_s[k]) line_chg_s = 1'b1;
      else line_chg_s = line_chg_s;
    end
    sum_s = {{(SW - SCORE_W){1'b0}}, score_r} + gain_s;
    if (sum_s > {{(SW - SCORE_W){1'b0}}, SCORE_MAX}) score_nx_s = SCORE_MAX;
    else score_nx_s = sum_s[SCORE_W-1:0];
  end

  // Spawn probe and end-of-game board scan.
  always_comb begin
    logic [EXP_W-1:0] e;
    spawn_hit_s = (cell_at(board_r, int'(spawn_idx_r)) == '0);
    spawn_end_s = spawn_hit_s || (spawn_cnt_r == IDXW'(N * N - 1));
    spawn_val_s = (lfsr_r[15:13] == 3'b111) ? EXP_W'(2) : EXP_W'(1);
    any_win_s = 1'b0; any_empty_s = 1'b0; any_pair_s = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        e = cell_at(board_r, r * N + c);
        if ({1'b0, e} >= WIN_E) any_win_s = 1'b1;
        else any_win_s = any_win_s;
        if (e == '0) any_empty_s = 1'b1;
        else any_empty_s = any_empty_s;
        if (c < N - 1 && e == cell_at(board_r, r * N + c + 1)) any_pair_s = 1'b1;
        else if (r < N - 1 && e == cell_at(board_r, (r + 1) * N + c)) any_pair_s = 1'b1;
        else any_pair_s = any_pair_s;
      end
    end
  end

  // Next-state logic; start_spawn_s reloads the scan start from the LFSR.
  always_comb begin
    state_nx_s    = state_r;
    start_spawn_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (load_valid) state_nx_s = S_CHECK;
        else if (move_valid) state_nx_s = S_SHIFT;
        else state_nx_s = S_IDLE;
      end
      S_SHIFT: begin
        if (line_r == LW'(N - 1)) begin
          if (changed_r | line_chg_s) begin
            state_nx_s    = S_SPAWN;
            start_spawn_s = 1'b1;
          end else begin
            state_nx_s = S_CHECK;
          end
        end else begin
          state_nx_s = S_SHIFT;
        end
      end
      S_SPAWN: begin
        if (spawn_end_s) begin
          if (boot_r) begin
            state_nx_s    = S_SPAWN;
            start_spawn_s = 1'b1;
          end else begin
            state_nx_s = S_CHECK;
          end
        end else begin
          state_nx_s = S_SPAWN;
        end
      end
      S_CHECK: begin
        if (any_win_s) state_nx_s = S_WON;
        else if (!any_empty_s && !any_pair_s) state_nx_s = S_LOST;
        else state_nx_s = S_IDLE;
      end
      S_WON, S_LOST: begin
        if (load_valid) state_nx_s = S_CHECK;
        else state_nx_s = state_r;
      end
      default: state_nx_s = S_IDLE;
    endcase
  end

  // State register; reset lands in the first of the two start-up spawn passes.
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_SPAWN;
    else state_r <= state_nx_s;
  end

  // Board, score, LFSR and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      board_r      <= '0;
      score_r      <= '0;
      lfsr_r       <= SEED;
      dir_r        <= 2'd0;
      line_r       <= '0;
      changed_r    <= 1'b0;
      spawn_idx_r  <= SEED[IDXW-1:0];
      spawn_cnt_r  <= '0;
      boot_r       <= 1'b1;
      op_r         <= 1'b0;
      done_r       <= 1'b0;
      moved_r      <= 1'b0;
      won_r        <= 1'b0;
      lost_r       <= 1'b0;
      move_ready_r <= 1'b0;
    end else begin
      lfsr_r       <= {lfsr_r[14:0], lfsr_fb_s};
      done_r       <= 1'b0;
      move_ready_r <= (state_nx_s == S_IDLE);
      case (state_r)
        S_IDLE, S_WON, S_LOST: begin
          if (load_valid) begin
            board_r   <= load_board;
            score_r   <= '0;
            won_r     <= 1'b0;
            lost_r    <= 1'b0;
            changed_r <= 1'b0;
            op_r      <= 1'b1;
          end else if (state_r == S_IDLE && move_valid) begin
            dir_r     <= move_dir;
            line_r    <= '0;
            changed_r <= 1'b0;
            op_r      <= 1'b1;
          end
        end
        S_SHIFT: begin
          for (int k = 0; k < N; k++) board_r[int'(lidx_s[k])*EXP_W +: EXP_W] <= res_s[k];
          score_r   <= score_nx_s;
          changed_r <= changed_r | line_chg_s;
          line_r    <= line_r + LW'(1);
        end
        S_SPAWN: begin
          if (spawn_hit_s) board_r[int'(spawn_idx_r)*EXP_W +: EXP_W] <= spawn_val_s;
          spawn_idx_r <= spawn_idx_r + IDXW'(1);
          spawn_cnt_r <= spawn_cnt_r + IDXW'(1);
          if (spawn_end_s) boot_r <= 1'b0;
        end
        S_CHECK: begin
          done_r <= op_r;
          if (op_r) moved_r <= changed_r;
          op_r   <= 1'b0;
          won_r  <= (state_nx_s == S_WON);
          lost_r <= (state_nx_s == S_LOST);
        end
        default: ;
      endcase
      if (start_spawn_s) begin
        spawn_idx_r <= lfsr_r[IDXW-1:0];
        spawn_cnt_r <= '0;
      end
    end
  end

  assign board      = board_r;
  assign score      = score_r;
  assign state      = state_r;
  assign done       = done_r;
  assign moved      = moved_r;
  assign won        = won_r;
  assign lost       = lost_r;
  assign move_ready = move_ready_r;

endmodule

// File: tb/tb_game_2048_core.sv
`timescale 1ns/1ps
// Directed bench for game_2048_core: hand-computed boards, scores and state outcomes.
module tb_game_2048_core;

  localparam int N = 4;
  localparam int EXP_W = 4;
  localparam int SCORE_W = 20;
  localparam int BW = N * N * EXP_W;

  logic              clk;
  logic              rst;
  logic              move_valid;
  logic [1:0]        move_dir;
  logic              move_ready;
  logic              load_valid;
  logic [BW-1:0]     load_board;
  logic [BW-1:0]     board;
  logic [SCORE_W-1:0] score;
  logic [2:0]        state;
  logic              done, moved, won, lost;

  int checks = 0;
  int errors = 0;
  int shift_cycles, spawn_cycles, dones;
  logic got_done, idle_seen;
  logic [BW-1:0] snap, hold;
  logic [BW-1:0] chk;

  game_2048_core #(.N(N), .EXP_W(EXP_W), .WIN_EXP(11), .SCORE_W(SCORE_W), .SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .move_valid(move_valid), .move_dir(move_dir), .move_ready(move_ready),
    .load_valid(load_valid), .load_board(load_board), .board(board), .score(score),
    .state(state), .done(done), .moved(moved), .won(won), .lost(lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int count_nz(input logic [BW-1:0] b);
    int n = 0;
    for (int i = 0; i < N * N; i++) if (b[i*EXP_W +: EXP_W] != 4'd0) n++;
    return n;
  endfunction

  function automatic int max_cell(input logic [BW-1:0] b);
    int m = 0;
    for (int i = 0; i < N * N; i++) if (int'(b[i*EXP_W +: EXP_W]) > m) m = int'(b[i*EXP_W +: EXP_W]);
    return m;
  endfunction

  task automatic do_load(input logic [BW-1:0] b, input logic also_move);
    load_board = b; load_valid = 1'b1; move_valid = also_move; move_dir = 2'd3;
    @(negedge clk);
    load_valid = 1'b0; move_valid = 1'b0;
  endtask

  task automatic do_move(input logic [1:0] d);
    move_dir = d; move_valid = 1'b1;
    @(negedge clk);
    move_valid = 1'b0;
  endtask

  task automatic watch(input int max_cycles);
    shift_cycles = 0; spawn_cycles = 0; got_done = 1'b0; snap = '0;
    for (int i = 0; i < max_cycles; i++) begin
      if (state == 3'd1) shift_cycles++;
      if (state == 3'd2) begin
        if (spawn_cycles == 0) snap = board;
        spawn_cycles++;
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    idle_seen = 1'b0; dones = 0;
    for (int i = 0; i < max_cycles; i++) begin
      if (done) dones++;
      if (state == 3'd0) begin
        idle_seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; move_valid = 1'b0; move_dir = 2'd0; load_valid = 1'b0; load_board = '0;
    repeat (3) @(negedge clk);
    check("rst_board", board, 64'h0);
    check("rst_score", score, 64'h0);
    check("rst_state", state, 64'd2);
    check("rst_flags", {move_ready, done, moved, won, lost}, 64'h0);
    rst = 1'b0;
    wait_idle(2 * N * N + 4);
    check("boot_idle", idle_seen, 64'd1);
    check("boot_cells", count_nz(board), 64'd2);
    check("boot_no_done", dones, 64'd0);
    check("boot_ready", move_ready, 64'd1);

    // Slide-left with two merges: [1,1,2,2] -> [2,3,0,0], score 4+8.
    do_load(64'h2211, 1'b0);
    watch(20);
    check("t1_load_done", got_done, 64'd1);
    check("t1_load_board", board, 64'h2211);
    check("t1_load_moved", moved, 64'd0);
    do_move(2'd3);
    watch(60);
    check("t1_shift_cycles", shift_cycles, 64'd4);
    check("t1_post_shift", snap, 64'h32);
    check("t1_done", got_done, 64'd1);
    check("t1_moved", moved, 64'd1);
    check("t1_score", score, 64'd12);
    check("t1_row0", board[7:0], 64'h32);
    chk = board & ~64'hFF;
    check("t1_new_cells", count_nz(chk), 64'd1);
    check("t1_new_val", (max_cell(chk) == 1 || max_cell(chk) == 2), 64'd1);

    // Slide-right on four equal tiles: two merges toward the wall.
    do_load(64'h1111, 1'b0);
    watch(20);
    do_move(2'd0);
    watch(60);
    check("t2_shift_cycles", shift_cycles, 64'd4);
    check("t2_post_shift", snap, 64'h2200);
    check("t2_score", score, 64'd8);
    check("t2_moved", moved, 64'd1);

    // A move that changes nothing: no spawn, moved stays 0.
    do_load(64'h4321, 1'b0);
    watch(20);
    do_move(2'd3);
    watch(60);
    check("t3_done", got_done, 64'd1);
    check("t3_board", board, 64'h4321);
    check("t3_score", score, 64'd0);
    check("t3_moved", moved, 64'd0);
    check("t3_spawn_cycles", spawn_cycles, 64'd0);

    // Load and move in the same cycle: only the load happens.
    do_load(64'h0011, 1'b1);
    watch(20);
    check("t4_done", got_done, 64'd1);
    check("t4_shift_cycles", shift_cycles, 64'd0);
    check("t4_board", board, 64'h0011);
    check("t4_moved", moved, 64'd0);

    // Vertical merge reaching the winning exponent.
    do_load(64'h000A_000A, 1'b0);
    watch(20);
    check("t5_load_state", state, 64'd0);
    do_move(2'd1);
    watch(60);
    check("t5_post_shift", snap, 64'hB);
    check("t5_done", got_done, 64'd1);
    check("t5_state", state, 64'd4);
    check("t5_won", won, 64'd1);
    check("t5_ready", move_ready, 64'd0);
    check("t5_score", score, 64'd2048);
    check("t5_cell00", board[3:0], 64'hB);
    hold = board;
    do_move(2'd3);
    repeat (4) @(negedge clk);
    check("t5_ignored_board", board, hold);
    check("t5_ignored_state", state, 64'd4);

    // Checkerboard has no empty cell and no equal neighbour.
    do_load(64'h1212_2121_1212_2121, 1'b0);
    watch(20);
    check("t6_done", got_done, 64'd1);
    check("t6_state", state, 64'd5);
    check("t6_lost", lost, 64'd1);
    check("t6_won_cleared", won, 64'd0);
    do_load(64'h0, 1'b0);
    watch(20);
    check("t6_reload_state", state, 64'd0);
    check("t6_reload_lost", lost, 64'd0);
    check("t6_reload_board", board, 64'h0);

    // Reset in the second SHIFT cycle, then the start-up sequence again.
    do_load(64'h2211, 1'b0);
    watch(20);
    do_move(2'd3);
    check("t7_shift1", state, 64'd1);
    @(negedge clk);
    check("t7_shift2", state, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t7_rst_board", board, 64'h0);
    check("t7_rst_score", score, 64'h0);
    check("t7_rst_flags", {move_ready, done, moved, won, lost}, 64'h0);
    rst = 1'b0;
    wait_idle(2 * N * N + 4);
    check("t7_idle", idle_seen, 64'd1);
    check("t7_cells", count_nz(board), 64'd2);
    check("t7_no_done", dones, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
